// File: rtl/life_grid_engine.sv
// life_grid_engine: Conway's Game of Life (B3/S23) engine over a ROWS x COLS grid.
// All cells are evolved in parallel in one clock. A small IDLE/RUN/HALT
// controller handles continuous and single-step evolution.
// Cell (r,c) is stored at bit (ROWS-1-r)*COLS+(COLS-1-c), so row 0 is the
// most significant group of bits.
// Optional build macro: LIFE_LFSR_EN adds a ROWS*COLS-bit Galois LFSR that
// lfsr_begin can copy into the grid. Without the macro, lfsr_begin does nothing.
module life_grid_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 load,
  input  logic                 lfsr_begin,
  input  logic                 wrap_en,
  input  logic [ROWS*COLS-1:0] seed,
  output logic [ROWS*COLS-1:0] grid_evolve,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;
  logic [N-1:0]     next_grid;
  logic             lfsr_load;
  logic [N-1:0]     lfsr_value;

  // Flat bit position of cell (r,c).
  function automatic int cell_idx(input int r, input int c);
    return (ROWS - 1 - r) * COLS + (COLS - 1 - c);
  endfunction

  // Read a neighbour. The row and column may be one step outside the grid.
  // On a torus the indices wrap. Otherwise any cell outside the grid is dead.
  function automatic logic cell_at(input logic [N-1:0] g, input int r,
                                   input int c, input logic wrap);
    int   rr;
    int   cc;
    logic in_grid;
    in_grid = (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    rr      = (r + ROWS) % ROWS;
    cc      = (c + COLS) % COLS;
    return (in_grid || wrap) ? g[cell_idx(rr, cc)] : 1'b0;
  endfunction

  // Per-cell neighbour count and B3/S23 rule, built for every cell in parallel.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic [3:0] nbr_cnt;
      logic       alive;

      assign alive = grid_q[cell_idx(gi, gj)];

      // Sum the eight surrounding cells.
      always_comb begin
        nbr_cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
              nbr_cnt = nbr_cnt + {3'b000, cell_at(grid_q, gi + dr, gj + dc, wrap_en)};
            end
          end
        end
      end

      assign next_grid[cell_idx(gi, gj)] =
        alive ? ((nbr_cnt == 4'd2) || (nbr_cnt == 4'd3)) : (nbr_cnt == 4'd3);
    end
  end

`ifdef LIFE_LFSR_EN
  // This is a fixed two-tap mask (top two bits). It is not guaranteed to give
  // a maximal-length sequence for every grid size.
  localparam logic [N-1:0] LFSR_TAPS = {2'b11, {(N-2){1'b0}}};

  logic [N-1:0] lfsr_q, lfsr_d;

  // Galois right-shift step. The output bit feeds back through the tap mask.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[N-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : {N{1'b0}});
  end

  // The LFSR runs freely every cycle and restarts from all-ones on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= {N{1'b1}};
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_load  = lfsr_begin;
  assign lfsr_value = lfsr_q;
`else
  logic unused_lfsr_begin;
  assign unused_lfsr_begin = lfsr_begin;
  assign lfsr_load         = 1'b0;
  assign lfsr_value        = {N{1'b0}};
`endif

  // Next-state logic. Priority is load, then LFSR load, then state-driven
  // evolution.
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;

    if (load || lfsr_load) begin
      grid_d    = load ? seed : lfsr_value;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = load ? (seed == '0) : (lfsr_value == '0);
      state_d   = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
          end else if (step) begin
            if (next_grid == grid_q) begin
              stable_d = 1'b1;
            end else begin
              grid_d    = next_grid;
              gen_d     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
              stable_d  = 1'b0;
              extinct_d = (next_grid == '0);
            end
          end
        end
        S_RUN: begin
          if (!start) begin
            state_d = S_IDLE;
          end else if (next_grid == grid_q) begin
            stable_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            grid_d    = next_grid;
            gen_d     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
            stable_d  = 1'b0;
            extinct_d = (next_grid == '0);
            if (next_grid == '0) begin
              state_d = S_HALT;
            end
          end
        end
        S_HALT: begin
          if (!start) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers. Reset overrides every input, including an evolution in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign grid_evolve = grid_q;
  assign gen_count   = gen_q;
  assign running     = (state_q == S_RUN);
  assign stable      = stable_q;
  assign extinct     = extinct_q;

endmodule

// File: doc/life_grid_engine.md
LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning grid row count (>=3).
REQ-002 SHALL have parameter COLS, default 8, meaning grid column count (>=3).
REQ-003 SHALL have parameter GEN_W, default 16, meaning generation counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level; run continuous evolution while high.
REQ-007 SHALL have port step  input  1  single-cycle pulse; evolve exactly one generation.
REQ-008 SHALL have port load  input  1  load seed into the grid.
REQ-009 SHALL have port lfsr_begin  input  1  load the internal LFSR value into the grid.
REQ-010 SHALL have port wrap_en  input  1  1 = toroidal edges, 0 = out-of-grid cells dead.
REQ-011 SHALL have port seed  input  ROWS*COLS  initial pattern.
REQ-012 SHALL have port grid_evolve  output  ROWS*COLS  current registered grid.
REQ-013 SHALL have port gen_count  output  GEN_W  generations evolved since the last load.
REQ-014 SHALL have port running  output  1  high while state is RUN.
REQ-015 SHALL have port stable  output  1  grid reached a fixed point.
REQ-016 SHALL have port extinct  output  1  grid is all zero.

Function
REQ-017 SHALL map cell (r,c) to bit (ROWS-1-r)*COLS+(COLS-1-c): row 0 is the MSB group, column 0 the MSB of each group.
REQ-018 SHALL compute the next generation with B3/S23: a dead cell with exactly 3 live neighbours is born; a live cell with 2 or 3 survives; every other cell is dead.
REQ-019 SHALL count 8 neighbours per cell, with indices wrapping modulo ROWS/COLS when wrap_en=1 and out-of-range neighbours read as 0 when wrap_en=0; wrap_en is sampled every evolving cycle.
REQ-020 SHALL implement states IDLE, RUN and HALT, with IDLE as the reset state.
REQ-021 SHALL, in IDLE, enter RUN on the next edge when start=1, with no evolution on that edge.
REQ-022 SHALL, in IDLE with start=0 and step=1, evolve one generation and remain in IDLE.
REQ-023 SHALL, in RUN with start=1, evolve one generation on every edge.
REQ-024 SHALL, in RUN, return to IDLE when start=0, with no evolution on that edge.
REQ-025 SHALL, on any evolution whose next grid equals the current grid, leave grid and gen_count unchanged, set stable=1 and enter HALT if in RUN.
REQ-026 SHALL, on any evolution whose next grid is all zero, update the grid, increment gen_count, set extinct=1 and enter HALT if in RUN.
REQ-027 SHALL, in HALT, ignore step and return to IDLE when start=0.
REQ-028 SHALL increment gen_count on each evolution that changes the grid, saturating at all-ones.
REQ-029 SHALL apply the priority reset > load > lfsr_begin > evolve; load or lfsr_begin in any state replaces the grid, clears gen_count, stable and extinct, forces IDLE, and sets extinct=1 if the loaded value is zero.
REQ-030 SHALL ignore step in RUN, and in IDLE when start=1 on the same edge.

Reset
REQ-031 SHALL, on reset, set grid_evolve=0, gen_count=0, running=0, stable=0, extinct=1 and state=IDLE, overriding all inputs.
REQ-032 SHALL, on reset asserted mid-RUN, discard the in-flight generation.

Configuration
REQ-033 SHALL, when macro LIFE_LFSR_EN is defined, include a ROWS*COLS-bit Galois LFSR that resets to all-ones and advances every cycle; lfsr_begin then loads its current value.
REQ-034 SHALL, when LIFE_LFSR_EN is undefined, omit the LFSR and treat lfsr_begin as a no-op.

Verification
REQ-035 SHALL cover: 8x8 blinker (rows 3, cols 2-4) loaded, start=1 -> grid alternates vertical/horizontal each cycle, gen_count=1,2,3...
REQ-036 SHALL cover: 2x2 block loaded, start=1 -> first evolution sets stable=1, gen_count=0, state HALT; start=0 -> IDLE.
REQ-037 SHALL cover: single live cell, step pulse -> grid=0, extinct=1, gen_count=1, state stays IDLE.
REQ-038 SHALL cover: 8x8 glider with wrap_en=1, 32 evolutions -> grid equals seed and gen_count=32; with wrap_en=0 -> eventual stable=1 HALT.
REQ-039 SHALL cover: reset asserted mid-RUN and load asserted together with start -> reset values per REQ-031, and load wins over evolve with gen_count=0.
REQ-040 SHALL cover: LIFE_LFSR_EN defined, lfsr_begin on the first post-reset cycle -> grid=all-ones; undefined -> grid unchanged.
